countdown: RTL
==============

# countdown

Programmable down-counter timer, the decrementing counterpart of the free-running up-counter. It loads a start value, decrements once per enabled clock, and emits a one-cycle `done` pulse when the count reaches zero. It sits beside the up-counter as a delay/timeout source for controllers that need "wait N cycles then act". An optional compile-time feature adds auto-reload for periodic ticks.

## Interface
- `WIDTH`, default 3: counter and load-value width in bits.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-low reset. Asserting it (0) resets all state immediately, with no clock edge needed. Deassertion is synchronous to `clk` upstream.
- `start` input 1: load `load_val` and begin counting; sampled on each `clk` rising edge.
- `load_val` input WIDTH: initial count, unsigned. Captured only when `start`=1.
- `stop` input 1: abort the count and return to IDLE. The count value is held.
- `pause` input 1: freeze the count while in RUN.
- `count` output WIDTH: current counter value, registered.
- `busy` output 1: high in RUN.
- `done` output 1: high for exactly one cycle, in DONE.

## Operation
- State machine states are IDLE, RUN and DONE. In reset, state=IDLE, `count`=0, reload register=0, `busy`=0, `done`=0.
- Input priority on each edge is `start` > `stop` > `pause`. This applies in every state.
- `start`=1, from any state:
  - `count` and the reload register take `load_val`.
  - Next state is RUN if `load_val`≠0, otherwise DONE.
- `stop`=1 with `start`=0: next state is IDLE. `count` is unchanged and no `done` pulse is produced.
- IDLE with no command: hold state and hold `count`.
- RUN behaviour:
  - With `pause`=1, `count` holds.
  - Otherwise `count` becomes `count`−1.
  - When `count`=1 and it decrements, `count` becomes 0 and next state is DONE.
- DONE (no command):
  - Without reload, go to IDLE with `count` staying 0.
  - With reload, see Configuration.
- Arithmetic is unsigned modulo 2^WIDTH. Decrement is never applied at `count`=0 in RUN, because that state is unreachable, so there is no wrap-around.
- Outputs are decoded from the registered state: `busy`=(state==RUN) and `done`=(state==DONE). No combinational path runs from any input to any output.

## Timing
- If `start` is sampled at edge E0 with `load_val`=N, then `count`=N after E0.
- `done` is high in the cycle following edge EN, i.e. N edges after the load edge when there is no pause.
- `load_val`=0 makes `done` high in the cycle right after E0.
- Each paused cycle extends the latency by one.
- `start` while in RUN restarts immediately with the new value. The previous count produces no `done`.
- `start` while in DONE: `done` is still high in that cycle, because it is state-decoded. The next state follows the `start` rule.
- If `rst` is asserted mid-count, all outputs go to their reset values asynchronously. No `done` is generated.

## Configuration
- `COUNTDOWN_RELOAD_EN` defined: DONE reloads `count` from the reload register.
  - Reload value ≠0: next state is RUN, giving a `done` period of reload+1 cycles.
  - Reload value =0: stay in DONE, so `done` is continuously high until `start` or `stop`.
  - `stop` is the only way to reach IDLE.
- Not defined: DONE always returns to IDLE. The reload register is not implemented, and `start` loads `count` only.

## Structure
- Package `countdown_pkg` holds the state enum (IDLE, RUN, DONE) and the default width constant.
- One sub-module, `dec`: combinational WIDTH-bit decrementer (o = i − 1), instantiated once to feed the count register.

## Test plan
- Reset with `rst`=0 mid-RUN at `count`=5 → `count`=0, `busy`=0 and `done`=0 immediately, without waiting for a clock edge.
- `start` with `load_val`=3, then idle inputs → `count` goes 3,2,1,0. `busy` is high for 3 cycles. `done` is high exactly 3 edges after the load edge, then the block is in IDLE with `count`=0.
- `load_val`=4 with `pause` high for 2 cycles after the second decrement → `done` is delayed to 6 edges after the load. `count` holds 2 while paused.
- `start`(`load_val`=5), then `start`(`load_val`=2) at `count`=3 → no `done` for the first load; `done` comes 2 edges after the second load. Also: `start` with `stop` on the same edge → `start` wins.
- `stop` at `count`=2 → IDLE, `count` holds 2, no `done`. `start` with `load_val`=0 → `done` high on the next cycle.
- With `COUNTDOWN_RELOAD_EN` and `load_val`=2 → `done` every 3 cycles across 4 periods. `stop` ends the sequence with no further `done`.

Source files
------------

// File: rtl/countdown_pkg.sv
// rtl/countdown_pkg.sv - shared state encoding and default width for the countdown timer
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/countdown_dec.sv
// rtl/countdown_dec.sv - combinational WIDTH-bit decrementer feeding the count register
module dec #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] o
);

  assign o = i - WIDTH'(1);

endmodule

// File: rtl/countdown.sv
// rtl/countdown.sv - programmable down-counter with one-cycle done pulse
// Optional auto-reload of the start value in DONE when COUNTDOWN_RELOAD_EN is defined.
module countdown
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             stop,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] count_dec;

  dec #(.WIDTH(WIDTH)) u_dec (
    .i (count),
    .o (count_dec)
  );

`ifdef COUNTDOWN_RELOAD_EN
  logic [WIDTH-1:0] reload;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload <= '0;
    end else if (start) begin
      reload <= load_val;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else if (start) begin
      count <= load_val;
      state <= (load_val != '0) ? RUN : DONE;
    end else if (stop) begin
      state <= IDLE;
    end else begin
      case (state)
        RUN: begin
          // count==0 is never seen in RUN, so the decrement cannot wrap
          if (!pause) begin
            count <= count_dec;
            if (count == WIDTH'(1)) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
`ifdef COUNTDOWN_RELOAD_EN
          count <= reload;
          state <= (reload != '0) ? RUN : DONE;
`else
          state <= IDLE;
`endif
        end
        default: state <= state;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
